// File: rtl/fprint_comparator_pkg.sv
// Shared types and default widths for the fingerprint comparator.
package fprint_comparator_pkg;

  localparam int CRC_WIDTH      = 32;
  localparam int RAM_ADDR_WIDTH = 4;
  localparam int KEY_WIDTH      = 4;
  localparam int KEY_SIZE       = 16;
  localparam int PTR_WIDTH      = RAM_ADDR_WIDTH + 1;
  localparam int CNT_WIDTH      = 8;

  typedef logic [CRC_WIDTH-1:0]      crc_t;
  typedef logic [PTR_WIDTH-1:0]      ptr_t;
  typedef logic [RAM_ADDR_WIDTH-1:0] addr_t;
  typedef logic [KEY_WIDTH-1:0]      key_t;
  typedef logic [KEY_SIZE-1:0]       mask_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ       = 3'd1,
    ST_COMPARE    = 3'd2,
    ST_RESET_TASK = 3'd3,
    ST_REPORT     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FAULT_CORE0   = 2'd0,
    FAULT_CORE1   = 2'd1,
    FAULT_CORE2   = 2'd2,
    FAULT_UNKNOWN = 2'd3
  } fault_t;

endpackage

// File: rtl/fprint_comparator_if.sv
// Bundle between fprint_registers / status consumer and the comparator.
// master = comparator side, slave = register file and status consumer side.
interface fprint_comparator_if;
  import fprint_comparator_pkg::*;

  crc_t  fprint_0;
  crc_t  fprint_1;
  crc_t  fprint_2;
  ptr_t  fprint_head_pointer_0;
  ptr_t  fprint_head_pointer_1;
  ptr_t  fprint_head_pointer_2;
  addr_t comp_tail_pointer_0;
  addr_t comp_tail_pointer_1;
  addr_t comp_tail_pointer_2;
  key_t  comp_task_id;
  mask_t fprint_nmr;
  mask_t fprint_checkin;
  logic  fprint_reset_task;
  logic  fprint_reset_task_ack;
  key_t  comparator_task_id;
  logic  status_valid;
  logic  status_mismatch;
  logic  [1:0] status_faulty_core;
  key_t  status_task_id;
  logic  [CNT_WIDTH-1:0] status_mismatch_count;

  modport master (
    input  fprint_0, fprint_1, fprint_2,
    input  fprint_head_pointer_0, fprint_head_pointer_1, fprint_head_pointer_2,
    input  comp_task_id, fprint_nmr, fprint_checkin, fprint_reset_task_ack,
    output comp_tail_pointer_0, comp_tail_pointer_1, comp_tail_pointer_2,
    output fprint_reset_task, comparator_task_id,
    output status_valid, status_mismatch, status_faulty_core, status_task_id,
    output status_mismatch_count
  );

  modport slave (
    output fprint_0, fprint_1, fprint_2,
    output fprint_head_pointer_0, fprint_head_pointer_1, fprint_head_pointer_2,
    output comp_task_id, fprint_nmr, fprint_checkin, fprint_reset_task_ack,
    input  comp_tail_pointer_0, comp_tail_pointer_1, comp_tail_pointer_2,
    input  fprint_reset_task, comparator_task_id,
    input  status_valid, status_mismatch, status_faulty_core, status_task_id,
    input  status_mismatch_count
  );
endinterface

// File: rtl/fprint_comparator_vote.sv
// Combinational majority vote over up to three fingerprints (DMR when tmr_i = 0).
module fprint_vote
  import fprint_comparator_pkg::*;
(
  input  crc_t   fp0_i,
  input  crc_t   fp1_i,
  input  crc_t   fp2_i,
  input  logic   tmr_i,
  output logic   mismatch_o,
  output fault_t faulty_o
);

  logic eq01, eq02, eq12;

  assign eq01 = (fp0_i == fp1_i);
  assign eq02 = (fp0_i == fp2_i);
  assign eq12 = (fp1_i == fp2_i);

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    mismatch_o = 1'b0;
    faulty_o   = FAULT_CORE0;
    if (!tmr_i) begin
      if (!eq01) begin
        mismatch_o = 1'b1;
        faulty_o   = FAULT_UNKNOWN;
      end
    end else if (!(eq01 && eq12)) begin
      mismatch_o = 1'b1;
      if (eq01)      faulty_o = FAULT_CORE2;
      else if (eq02) faulty_o = FAULT_CORE1;
      else if (eq12) faulty_o = FAULT_CORE0;
      else           faulty_o = FAULT_UNKNOWN;
    end
  end

endmodule

// File: rtl/fprint_comparator.sv
// Streams per-core fingerprints, votes a faulty core and reports once per task.
// Optional FPRINT_MISMATCH_COUNT_EN adds a saturating per-task mismatch counter.
module fprint_comparator
  import fprint_comparator_pkg::*;
(
  input logic          clk,
  input logic          reset,
  fprint_comparator_if.master bus
);

  state_t state_q, state_d;
  logic [2:0][PTR_WIDTH-1:0] tail_q, tail_d;
  logic [2:0][PTR_WIDTH-1:0] head;
  key_t   task_q, task_d;
  logic   mismatch_q, mismatch_d;
  fault_t fault_q, fault_d;

  logic   tmr;
  logic [2:0] empty, active;
  logic   all_ready, all_empty, start_reset;
  logic   vote_mismatch;
  fault_t vote_fault;

  logic   reset_task;
  logic   st_valid_d, st_mm_d;
  fault_t st_fault_d;
  key_t   st_id_d;
  logic   st_valid_q, st_mm_q;
  fault_t st_fault_q;
  key_t   st_id_q;

  assign head      = {bus.fprint_head_pointer_2, bus.fprint_head_pointer_1,
                      bus.fprint_head_pointer_0};
  assign tmr       = bus.fprint_nmr[bus.comp_task_id];
  assign active    = {tmr, 2'b11};
  // Full-width compare: the wrap bit separates "empty" from "full".
  assign empty[0]  = (tail_q[0] == head[0]);
  assign empty[1]  = (tail_q[1] == head[1]);
  assign empty[2]  = (tail_q[2] == head[2]);
  assign all_ready = &(~empty | ~active);
  assign all_empty = &(empty | ~active);
  assign start_reset = bus.fprint_checkin[bus.comp_task_id] && all_empty;

  fprint_vote u_vote (
    .fp0_i      (bus.fprint_0),
    .fp1_i      (bus.fprint_1),
    .fp2_i      (bus.fprint_2),
    .tmr_i      (tmr),
    .mismatch_o (vote_mismatch),
    .faulty_o   (vote_fault)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (all_ready)        state_d = ST_READ;
        else if (start_reset) state_d = ST_RESET_TASK;
      end
      ST_READ:       state_d = ST_COMPARE;
      ST_COMPARE:    state_d = ST_IDLE;
      ST_RESET_TASK: if (bus.fprint_reset_task_ack) state_d = ST_REPORT;
      ST_REPORT:     state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    reset_task = (state_q == ST_RESET_TASK);
    st_valid_d = 1'b0;
    st_mm_d    = 1'b0;
    st_fault_d = FAULT_CORE0;
    st_id_d    = '0;
    if (state_q == ST_REPORT) begin
      st_valid_d = 1'b1;
      st_mm_d    = mismatch_q;
      st_fault_d = fault_q;
      st_id_d    = task_q;
    end
  end

  always_comb begin
    tail_d     = tail_q;
    task_d     = task_q;
    mismatch_d = mismatch_q;
    fault_d    = fault_q;
    case (state_q)
      ST_IDLE: if (!all_ready && start_reset) task_d = bus.comp_task_id;
      ST_COMPARE: begin
        tail_d[0] = tail_q[0] + PTR_WIDTH'(1);
        tail_d[1] = tail_q[1] + PTR_WIDTH'(1);
        if (tmr) tail_d[2] = tail_q[2] + PTR_WIDTH'(1);
        if (vote_mismatch) begin
          mismatch_d = 1'b1;
          if (!mismatch_q) fault_d = vote_fault;
        end
      end
      // Snapping every tail also flushes core-2 data left over from a DMR task.
      ST_RESET_TASK: if (bus.fprint_reset_task_ack) tail_d = head;
      ST_REPORT: begin
        mismatch_d = 1'b0;
        fault_d    = FAULT_CORE0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tail_q     <= '0;
      task_q     <= '0;
      mismatch_q <= 1'b0;
      fault_q    <= FAULT_CORE0;
      st_valid_q <= 1'b0;
      st_mm_q    <= 1'b0;
      st_fault_q <= FAULT_CORE0;
      st_id_q    <= '0;
    end else begin
      tail_q     <= tail_d;
      task_q     <= task_d;
      mismatch_q <= mismatch_d;
      fault_q    <= fault_d;
      st_valid_q <= st_valid_d;
      st_mm_q    <= st_mm_d;
      st_fault_q <= st_fault_d;
      st_id_q    <= st_id_d;
    end
  end

`ifdef FPRINT_MISMATCH_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, st_cnt_q, st_cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    st_cnt_d = '0;
    if (state_q == ST_COMPARE && vote_mismatch && cnt_q != '1)
      cnt_d = cnt_q + CNT_WIDTH'(1);
    if (state_q == ST_REPORT) begin
      st_cnt_d = cnt_q;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      st_cnt_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign bus.status_mismatch_count = st_cnt_q;
`else
  assign bus.status_mismatch_count = '0;
`endif

  assign bus.comp_tail_pointer_0 = tail_q[0][RAM_ADDR_WIDTH-1:0];
  assign bus.comp_tail_pointer_1 = tail_q[1][RAM_ADDR_WIDTH-1:0];
  assign bus.comp_tail_pointer_2 = tail_q[2][RAM_ADDR_WIDTH-1:0];
  assign bus.fprint_reset_task   = reset_task;
  assign bus.comparator_task_id  = task_q;
  assign bus.status_valid        = st_valid_q;
  assign bus.status_mismatch     = st_mm_q;
  assign bus.status_faulty_core  = st_fault_q;
  assign bus.status_task_id      = st_id_q;

endmodule

// File: tb/tb_fprint_comparator.sv
// Scoreboard bench: stimulus queues expected status records, a monitor checks each status pulse.
module tb_fprint_comparator;
  import fprint_comparator_pkg::*;

  typedef struct packed {
    logic       mm;
    logic [1:0] fault;
    logic [3:0] id;
    logic [7:0] cnt;
  } status_exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fprint_comparator_if bus ();

  fprint_comparator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] ram0 [16];
  logic [31:0] ram1 [16];
  logic [31:0] ram2 [16];
  logic [4:0]  h0, h1, h2;

  int checks   = 0;
  int failures = 0;
  status_exp_t exp_q[$];
  status_exp_t mon_e;
  int cmp_cnt = 0;
  logic [3:0] prev_tail0 = '0;

  always @(posedge clk) begin
    bus.fprint_0 <= ram0[bus.comp_tail_pointer_0];
    bus.fprint_1 <= ram1[bus.comp_tail_pointer_1];
    bus.fprint_2 <= ram2[bus.comp_tail_pointer_2];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.status_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_status: actual task=%0d required no status", bus.status_task_id);
      end else begin
        mon_e = exp_q.pop_front();
        check("status_task_id", 32'(bus.status_task_id), 32'(mon_e.id));
        check("status_mismatch", 32'(bus.status_mismatch), 32'(mon_e.mm));
        check("status_faulty_core", 32'(bus.status_faulty_core), 32'(mon_e.fault));
        check("status_mismatch_count", 32'(bus.status_mismatch_count), 32'(mon_e.cnt));
      end
    end
  end

  always @(negedge clk) begin
    if (bus.comp_tail_pointer_0 != prev_tail0) cmp_cnt++;
    prev_tail0 = bus.comp_tail_pointer_0;
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input bit use2);
    ram0[h0[3:0]] = a;
    ram1[h1[3:0]] = b;
    h0 = h0 + 5'd1;
    h1 = h1 + 5'd1;
    if (use2) begin
      ram2[h2[3:0]] = c;
      h2 = h2 + 5'd1;
    end
  endtask

  task automatic apply_heads();
    bus.fprint_head_pointer_0 = h0;
    bus.fprint_head_pointer_1 = h1;
    bus.fprint_head_pointer_2 = h2;
  endtask

  task automatic wait_tail0(input logic [3:0] tgt, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.comp_tail_pointer_0 == tgt) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.fprint_reset_task) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic serve_reset(input string tag, input logic [3:0] id,
                             input logic [3:0] t0, input logic [3:0] t1, input logic [3:0] t2);
    bit ok;
    wait_req(ok);
    check({tag, "_req_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      bus.fprint_checkin = '0;
      check({tag, "_req_id"}, 32'(bus.comparator_task_id), 32'(id));
      check({tag, "_tail0"}, 32'(bus.comp_tail_pointer_0), 32'(t0));
      check({tag, "_tail1"}, 32'(bus.comp_tail_pointer_1), 32'(t1));
      check({tag, "_tail2"}, 32'(bus.comp_tail_pointer_2), 32'(t2));
      @(negedge clk);
      check({tag, "_req_held"}, 32'(bus.fprint_reset_task), 32'd1);
      bus.fprint_reset_task_ack = 1'b1;
      @(negedge clk);
      bus.fprint_reset_task_ack = 1'b0;
      repeat (3) @(negedge clk);
      check({tag, "_req_dropped"}, 32'(bus.fprint_reset_task), 32'd0);
      check({tag, "_snap2"}, 32'(bus.comp_tail_pointer_2), 32'(h2[3:0]));
      check({tag, "_status_seen"}, 32'(exp_q.size()), 32'd0);
    end
  endtask

  initial begin
    bit ok;
    logic [7:0] cnt_exp;
    for (int i = 0; i < 16; i++) begin
      ram0[i] = '0;
      ram1[i] = '0;
      ram2[i] = '0;
    end
    h0 = '0; h1 = '0; h2 = '0;
    apply_heads();
    bus.comp_task_id          = '0;
    bus.fprint_nmr            = 16'h0898;
    bus.fprint_checkin        = '0;
    bus.fprint_reset_task_ack = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(bus.fprint_reset_task), 32'd0);
    check("rst_tail0", 32'(bus.comp_tail_pointer_0), 32'd0);
    check("rst_tail2", 32'(bus.comp_tail_pointer_2), 32'd0);
    check("rst_valid", 32'(bus.status_valid), 32'd0);
    check("rst_id", 32'(bus.comparator_task_id), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: TMR task 3, single matching entry
    bus.comp_task_id = 4'd3;
    push(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    apply_heads();
    bus.fprint_checkin = 16'h0008;
    exp_q.push_back('{mm: 1'b0, fault: 2'd0, id: 4'd3, cnt: 8'd0});
    serve_reset("t1", 4'd3, 4'd1, 4'd1, 4'd1);

    // 2: TMR task 4, core 2 faulty first, later core-0 mismatch ignored for the code
    bus.comp_task_id = 4'd4;
    push(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEE, 1'b1);
    push(32'h0000_0001, 32'h0000_0002, 32'h0000_0002, 1'b1);
    apply_heads();
    bus.fprint_checkin = 16'h0010;
`ifdef FPRINT_MISMATCH_COUNT_EN
    cnt_exp = 8'd2;
`else
    cnt_exp = 8'd0;
`endif
    exp_q.push_back('{mm: 1'b1, fault: 2'd2, id: 4'd4, cnt: cnt_exp});
    serve_reset("t2", 4'd4, 4'd3, 4'd3, 4'd3);

    // 3: DMR task 5, fp0 != fp1, one stray core-2 entry stays until the ack
    bus.comp_task_id = 4'd5;
    push(32'h0000_0001, 32'h0000_0002, 32'h0, 1'b0);
    ram2[h2[3:0]] = 32'h0000_0055;
    h2 = h2 + 5'd1;
    apply_heads();
    bus.fprint_checkin = 16'h0020;
`ifdef FPRINT_MISMATCH_COUNT_EN
    cnt_exp = 8'd1;
`else
    cnt_exp = 8'd0;
`endif
    exp_q.push_back('{mm: 1'b1, fault: 2'd3, id: 4'd5, cnt: cnt_exp});
    serve_reset("t3", 4'd5, 4'd4, 4'd4, 4'd3);

    // 4: TMR task 7, 20 entries through a 16-deep RAM with wrap
    bus.comp_task_id = 4'd7;
    @(negedge clk);
    cmp_cnt = 0;
    for (int i = 0; i < 12; i++) push(32'hA5A5_0000 + 32'(i), 32'hA5A5_0000 + 32'(i),
                                      32'hA5A5_0000 + 32'(i), 1'b1);
    apply_heads();
    wait_tail0(4'd0, "t4_wrap_reached");
    repeat (4) @(negedge clk);
    check("t4_wrap_tail1", 32'(bus.comp_tail_pointer_1), 32'd0);
    check("t4_wrap_tail2", 32'(bus.comp_tail_pointer_2), 32'd0);
    check("t4_no_early_req", 32'(bus.fprint_reset_task), 32'd0);
    for (int i = 0; i < 8; i++) push(32'h5A5A_0000 + 32'(i), 32'h5A5A_0000 + 32'(i),
                                     32'h5A5A_0000 + 32'(i), 1'b1);
    apply_heads();
    wait_tail0(4'd8, "t4_end_reached");
    @(negedge clk);
    check("t4_compares", 32'(cmp_cnt), 32'd20);
    check("t4_no_req", 32'(bus.fprint_reset_task), 32'd0);
    bus.fprint_checkin = 16'h0080;
    exp_q.push_back('{mm: 1'b0, fault: 2'd0, id: 4'd7, cnt: 8'd0});
    serve_reset("t4", 4'd7, 4'd8, 4'd8, 4'd8);

    // 6: TMR task 11, 3 of 5 entries mismatch, first fault is core 1
    bus.comp_task_id = 4'd11;
    push(32'h1111_1111, 32'h1111_1111, 32'h1111_1111, 1'b1);
    push(32'h2222_2222, 32'h2222_2223, 32'h2222_2222, 1'b1);
    push(32'h3333_3333, 32'h3333_3333, 32'h3333_3333, 1'b1);
    push(32'h4444_4440, 32'h4444_4444, 32'h4444_4444, 1'b1);
    push(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b1);
    apply_heads();
    bus.fprint_checkin = 16'h0800;
`ifdef FPRINT_MISMATCH_COUNT_EN
    cnt_exp = 8'd3;
`else
    cnt_exp = 8'd0;
`endif
    exp_q.push_back('{mm: 1'b1, fault: 2'd1, id: 4'd11, cnt: cnt_exp});
    serve_reset("t6", 4'd11, 4'd13, 4'd13, 4'd13);

    // 5: reset while waiting for an ack that never comes
    bus.comp_task_id = 4'd9;
    bus.fprint_checkin = 16'h0200;
    wait_req(ok);
    check("t5_req_seen", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    check("t5_req_waiting", 32'(bus.fprint_reset_task), 32'd1);
    reset = 1'b1;
    h0 = '0; h1 = '0; h2 = '0;
    apply_heads();
    bus.fprint_checkin = '0;
    @(negedge clk);
    check("t5_req_cleared", 32'(bus.fprint_reset_task), 32'd0);
    check("t5_tail0", 32'(bus.comp_tail_pointer_0), 32'd0);
    check("t5_tail1", 32'(bus.comp_tail_pointer_1), 32'd0);
    check("t5_valid", 32'(bus.status_valid), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_still_idle", 32'(bus.fprint_reset_task), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fprint_comparator.md
Name: fprint_comparator

Overview:
- Downstream consumer of the per-core fingerprint RAMs held in fprint_registers.
- Drives the per-core tail pointers and reads fprint_0/1/2 one entry at a time.
- Compares the entries across the active replicas (DMR or TMR per task) and majority-votes a faulty core.
- When a task is checked in on all replicas and its queues are drained, requests fprint_reset_task, waits for the ack, then emits one status pulse per task.

Parameters:
- CRC_WIDTH, 32, fingerprint width.
- RAM_ADDR_WIDTH, 4, log2 of fingerprint RAM depth (16 entries).
- KEY_WIDTH, 4, task id width.
- KEY_SIZE, 16, number of tasks (bitmask width).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fprint_0 / fprint_1 / fprint_2  in  CRC_WIDTH each  RAM read data; registered, valid one clk after the tail pointer.
- fprint_head_pointer_0 / 1 / 2  in  RAM_ADDR_WIDTH+1 each  per-core write pointer, MSB is the wrap bit.
- comp_tail_pointer_0 / 1 / 2  out  RAM_ADDR_WIDTH each  read addresses, low bits of the internal tails.
- comp_task_id  in  KEY_WIDTH  task currently streaming fingerprints.
- fprint_nmr  in  KEY_SIZE  per-task TMR enable (1 = TMR, 0 = DMR on cores 0/1).
- fprint_checkin  in  KEY_SIZE  per-task all-replicas-checked-in mask.
- fprint_reset_task  out  1  task reset request, level.
- fprint_reset_task_ack  in  1  one-cycle ack.
- comparator_task_id  out  KEY_WIDTH  task being reset.
- status_valid  out  1  one-cycle pulse, one per task.
- status_mismatch  out  1  any mismatch seen in the task.
- status_faulty_core  out  2  0/1/2 = voted faulty core; 3 = undetermined.
- status_task_id  out  KEY_WIDTH  task the status refers to.
- status_mismatch_count  out  8  see Optional Feature.

Behaviour:
- Reset (synchronous): state IDLE; tails 0; all outputs 0; mismatch flag and faulty code cleared.
- Active set: cores 0 and 1 always; core 2 only if fprint_nmr[comp_task_id].
- Pointer arithmetic:
  - Tails are RAM_ADDR_WIDTH+1 bits and wrap modulo 2^(RAM_ADDR_WIDTH+1).
  - Core k is empty when tail_k == head_k, with the full-width compare including the wrap bit.
- FSM:
  - IDLE:
    - If all active cores are non-empty, go to READ.
    - Else, if fprint_checkin[comp_task_id] and all active cores are empty, latch comparator_task_id = comp_task_id and go to RESET_TASK.
    - Comparison has priority over reset.
  - READ: one wait cycle for RAM data to settle; go to COMPARE.
  - COMPARE:
    - Evaluate the vote and increment the tail of every active core by 1.
    - On mismatch, set the sticky mismatch flag; the faulty code of the first mismatch is kept, later ones are ignored.
    - Go to IDLE.
  - RESET_TASK:
    - fprint_reset_task = 1; hold comparator_task_id stable.
    - On ack, snap all three tails to their heads (discards stray core-2 data in DMR) and go to REPORT.
  - REPORT:
    - status_valid = 1 with the flag, code and comparator_task_id.
    - Clear the flag and code; go to IDLE.
- Vote (TMR):
  - All equal: no mismatch.
  - Exactly one differs: faulty code = that core.
  - All three differ: faulty code = 3.
- Vote (DMR): fp0 != fp1 gives faulty code = 3.
- Throughput and latency: one compare per 3 clk. Status appears 2 clk after the ack (REPORT, then the pulse) plus the ack wait.
- Boundary cases:
  - A core becoming non-empty mid-REPORT is picked up on the next IDLE.
  - Heads are never ahead by more than the RAM depth; upstream guarantees no overflow.
  - fprint_checkin changing during RESET_TASK is ignored until IDLE.
  - comp_task_id is sampled only in IDLE and COMPARE.

Optional Feature:
- Macro: FPRINT_MISMATCH_COUNT_EN.
- Defined:
  - 8-bit saturating count (max 255) of mismatching COMPAREs per task, reported on status_mismatch_count in REPORT.
  - Cleared after REPORT and on reset.
- Undefined: status_mismatch_count is tied to 0 and no counter logic is built.

Decomposition:
- Shared package holds:
  - FSM state encodings (IDLE, READ, COMPARE, RESET_TASK, REPORT).
  - Faulty-core codes (FAULT_CORE0..2, FAULT_UNKNOWN = 3).
  - Default widths.
- One sub-module, fprint_vote:
  - Purely combinational.
  - Inputs: three fingerprints and tmr.
  - Outputs: mismatch and faulty code.

Test Plan:
1. TMR, task 3, one entry 0xDEADBEEF per core (heads = 1), checkin[3] = 1 → tails reach 1, reset request with id 3, ack → status_valid, mismatch 0, task 3.
2. TMR, fp2 = 0xDEADBEEE → mismatch 1, faulty 2. Second entry with fp0 differing → faulty stays 2.
3. DMR (nmr[5] = 0), fp0 = 1, fp1 = 2, head_2 = 0 → mismatch 1, faulty 3; tail_2 stays 0 until the ack.
4. 20 matching entries streamed into a 16-deep RAM, heads kept ahead → tails wrap 15→0 with wrap bit 1, 20 compares, no premature reset request.
5. Reset asserted while waiting in RESET_TASK with no ack → next cycle fprint_reset_task = 0, tails 0, no status_valid.
6. With FPRINT_MISMATCH_COUNT_EN, 3 mismatching entries out of 5 → status_mismatch_count = 3; without the macro it reads 0.
